osc_capture_mc: RTL
===================

// Module: osc_capture_mc
// PURPOSE
//  Multi-channel triggered capture buffer with an SVGA trace renderer for the scope overlay.
//  Stores N_CH sample streams in a circular buffer and supports a programmable pre-trigger window.
//  Trigger: rising or falling edge on a selected channel; modes are normal, single-shot and auto.
//  Sits between the sample source (mic/ADC deserialiser) and the SVGA pixel mux.
// PARAMETERS
//  DATA_W      16   sample width, signed two's complement
//  DEPTH_LOG2  10   log2 of buffer depth per channel (DEPTH = 2**DEPTH_LOG2)
//  N_CH        2    channel count, 1..4
//  V_SHIFT     7    arithmetic right shift applied to a sample before display (9-bit signed result)
//  Y_CENTER    384  screen row of the zero line
//  HOLD_FRAMES 16   frames a capture is held on screen in normal/auto mode
//  AUTO_FRAMES 8    frames without a trigger before auto mode forces one
// PORTS
//  clk        in   1             pixel/system clock
//  reset_n    in   1             asynchronous reset, active-low
//  data       in   N_CH*DATA_W   channel k at bits [k*DATA_W +: DATA_W]
//  data_we    in   1             one sample per channel is valid this cycle
//  threshold  in   DATA_W        signed trigger level
//  trig_ch    in   2             trigger channel; values >= N_CH select channel 0
//  trig_fall  in   1             0 = rising edge, 1 = falling edge
//  mode       in   2             0 = normal, 1 = single, 2 = auto, 3 = normal
//  arm        in   1             single-cycle pulse: starts or re-arms single mode
//  pretrig    in   DEPTH_LOG2    samples kept before the trigger point
//  x          in   12            pixel column
//  y          in   11            pixel row
//  vsync      in   1             active-low vsync
//  vga_r      out  4             red
//  vga_g      out  4             green
//  vga_b      out  4             blue
//  state      out  3             FSM state code
// BEHAVIOUR
//  Reset: FSM goes to IDLE; wr_ptr, counters and outputs go to 0. Buffer RAM is not cleared.
//   Reset mid-capture aborts the capture immediately.
//  FSM states (state code):
//   IDLE(0)  -> PRE next cycle if mode != 1. In single mode, wait for arm.
//   PRE(1)   -> ARMED once fill_cnt == pretrig_l.
//   ARMED(2) -> POST on trigger.
//   POST(3)  -> HOLD (or DONE in single mode) after DEPTH - pretrig_l more samples.
//   HOLD(4)  -> PRE after HOLD_FRAMES vsync falls.
//   DONE(5)  -> PRE on arm.
//  On every exit from IDLE/HOLD/DONE:
//   - latch mode_l, pretrig_l, trig_ch_l;
//   - clear fill_cnt and prev_valid.
//  Write path: in PRE/ARMED/POST, each data_we writes all channels at wr_ptr, then wr_ptr++
//   modulo DEPTH (wraps silently).
//  Trigger is evaluated only in ARMED, on data_we, and needs prev_valid. Comparisons are signed.
//   - rise: prev < threshold && cur >= threshold.
//   - fall: prev >= threshold && cur < threshold.
//  Trigger point: trig_ptr = wr_ptr of the triggering sample.
//   start_ptr = trig_ptr - pretrig_l mod DEPTH.
//  Auto mode: AUTO_FRAMES vsync falls while in ARMED force a trigger at the current wr_ptr.
//   A real trigger arriving in the same cycle as the forced one takes precedence; the result is identical.
//  Vsync fall is detected as vsync_z & ~vsync, registered; the frame counter counts in ARMED and HOLD.
//  arm pulses in states other than IDLE(single) or DONE are ignored.
//  Render: read address = start_ptr + x[DEPTH_LOG2-1:0]. RAM read is registered.
//   vga_* lags x/y by 2 clocks. Output is 0 unless state is HOLD or DONE and x < DEPTH.
//  Per channel: v = sample >>> V_SHIFT, saturated to [-256, 255].
//   lit when v>0 and Y_CENTER-v <= y < Y_CENTER, or v<0 and Y_CENTER < y <= Y_CENTER-v.
//   v == 0 lights row Y_CENTER only.
//  Colour (channels OR'd): ch0 -> g=F; ch1 -> r=F; ch2 -> b=F; ch3 -> r=g=b=F.
// TESTING
//  Reset mid-POST with reset_n=0 for 1 cycle -> state=0, vga_*=0, no further RAM writes.
//  N_CH=2, normal mode, ramp 0..1023 on ch0, threshold=500, pretrig=100, rising edge:
//   -> trig at sample 500, start_ptr addresses sample 400, state sequence 1,2,3,4;
//   -> HOLD lasts 16 vsync falls; then PRE.
//  Falling edge, ch1 = +1000 then -1000, threshold=0 -> trigger at first negative sample only; ch0 ignored.
//  Auto mode, constant data 0, threshold=100 -> forced trigger after the 8th vsync fall; HOLD follows.
//  Single mode: no arm -> stays IDLE.
//   arm -> capture, DONE is held across 50 frames; a second arm restarts PRE.
//  Render, V_SHIFT=7:
//   ch0 = 0x1000 -> v=32, rows 352..383 green;
//   ch1 = -0x0800 -> v=-16, rows 385..400 red;
//   x = 1024 -> black; both channels lit on the same pixel -> r=g=F.

Source files
------------

// File: rtl/osc_capture_mc.sv
// osc_capture_mc
//   Multi-channel triggered capture buffer with an SVGA trace renderer.
//   Samples from N_CH channels are written into a circular buffer. A capture
//   keeps a programmable pre-trigger window. The trigger is a rising or
//   falling threshold crossing on a selected channel. The held capture is
//   drawn as vertical bars around the screen row Y_CENTER.
// Ports
//   clk, reset_n            pixel/system clock, async active-low reset
//   data, data_we           N_CH packed signed samples plus a write strobe
//   threshold, trig_ch      signed trigger level and trigger channel
//   trig_fall               0 = rising edge, 1 = falling edge
//   mode, arm               capture mode (normal/single/auto) and re-arm pulse
//   pretrig                 samples kept before the trigger point
//   x, y, vsync             pixel position and active-low vsync
//   vga_r, vga_g, vga_b     4-bit colour, two clocks behind x/y
//   state                   FSM state code
module osc_capture_mc #(
  parameter int DATA_W      = 16,
  parameter int DEPTH_LOG2  = 10,
  parameter int N_CH        = 2,
  parameter int V_SHIFT     = 7,
  parameter int Y_CENTER    = 384,
  parameter int HOLD_FRAMES = 16,
  parameter int AUTO_FRAMES = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [N_CH*DATA_W-1:0] data,
  input  logic                   data_we,
  input  logic [DATA_W-1:0]      threshold,
  input  logic [1:0]             trig_ch,
  input  logic                   trig_fall,
  input  logic [1:0]             mode,
  input  logic                   arm,
  input  logic [DEPTH_LOG2-1:0]  pretrig,
  input  logic [11:0]            x,
  input  logic [10:0]            y,
  input  logic                   vsync,
  output logic [3:0]             vga_r,
  output logic [3:0]             vga_g,
  output logic [3:0]             vga_b,
  output logic [2:0]             state
);

  localparam int DEPTH     = 1 << DEPTH_LOG2;
  localparam int CNT_W     = DEPTH_LOG2 + 1;
  localparam int FRAME_MAX = (HOLD_FRAMES > AUTO_FRAMES) ? HOLD_FRAMES : AUTO_FRAMES;
  localparam int FRAME_W   = $clog2(FRAME_MAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_ARMED = 3'd2,
    ST_POST  = 3'd3,
    ST_HOLD  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  state_t                   state_q, state_d;
  logic [DEPTH_LOG2-1:0]    wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0]    start_ptr_q, start_ptr_d;
  logic [CNT_W-1:0]         fill_cnt_q, fill_cnt_d;
  logic [FRAME_W-1:0]       frame_cnt_q, frame_cnt_d;
  logic signed [DATA_W-1:0] prev_q, prev_d;
  logic                     prev_valid_q, prev_valid_d;
  logic [1:0]               mode_l_q, mode_l_d;
  logic [DEPTH_LOG2-1:0]    pretrig_l_q, pretrig_l_d;
  logic [1:0]               trig_ch_l_q, trig_ch_l_d;
  logic                     vsync_z_q, vsync_z_d;
  logic                     vfall_q, vfall_d;
  logic [10:0]              y_p1_q, y_p1_d;
  logic                     en_p1_q, en_p1_d;
  logic [3:0]               vga_r_q, vga_r_d, vga_g_q, vga_g_d, vga_b_q, vga_b_d;

  logic [N_CH*DATA_W-1:0]   mem [DEPTH];
  logic [N_CH*DATA_W-1:0]   rd_data_q;
  logic [DEPTH_LOG2-1:0]    rd_addr;
  logic                     we_ram;

  logic signed [DATA_W-1:0] cur_s, thr_s;
  logic [CNT_W-1:0]         post_target, trig_fill;
  logic                     real_trig, force_trig, start_capture;
  state_t                   end_state;

  // Pick the trigger channel sample; unpopulated channel numbers fall back to ch0.
  always_comb begin
    cur_s = data[DATA_W-1:0];
    for (int k = 0; k < N_CH; k++) begin
      if (trig_ch_l_q == 2'(k)) cur_s = data[k*DATA_W +: DATA_W];
    end
  end

  // Capture FSM and write path. The triggering sample itself counts as the
  // first post-trigger sample, so the buffer ends exactly one lap after
  // start_ptr and the oldest pre-trigger sample is never overwritten.
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    start_ptr_d   = start_ptr_q;
    fill_cnt_d    = fill_cnt_q;
    frame_cnt_d   = frame_cnt_q;
    prev_d        = prev_q;
    prev_valid_d  = prev_valid_q;
    mode_l_d      = mode_l_q;
    pretrig_l_d   = pretrig_l_q;
    trig_ch_l_d   = trig_ch_l_q;
    we_ram        = 1'b0;
    start_capture = 1'b0;
    thr_s         = threshold;
    post_target   = CNT_W'(DEPTH) - {1'b0, pretrig_l_q};
    trig_fill     = {{(CNT_W-1){1'b0}}, data_we};
    end_state     = (mode_l_q == 2'd1) ? ST_DONE : ST_HOLD;
    real_trig     = 1'b0;
    force_trig    = 1'b0;

    if ((state_q == ST_PRE || state_q == ST_ARMED || state_q == ST_POST) && data_we) begin
      we_ram       = 1'b1;
      wr_ptr_d     = wr_ptr_q + 1'b1;
      prev_d       = cur_s;
      prev_valid_d = 1'b1;
    end

    if (vfall_q && (state_q == ST_ARMED || state_q == ST_HOLD))
      frame_cnt_d = frame_cnt_q + 1'b1;

    case (state_q)
      ST_IDLE: if (mode != 2'd1 || arm) start_capture = 1'b1;
      ST_PRE: begin
        if (data_we) fill_cnt_d = fill_cnt_q + 1'b1;
        if (fill_cnt_q == {1'b0, pretrig_l_q}) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (data_we && prev_valid_q)
          real_trig = trig_fall ? (prev_q >= thr_s && cur_s < thr_s)
                                : (prev_q < thr_s && cur_s >= thr_s);
        force_trig = (mode_l_q == 2'd2) && vfall_q &&
                     (frame_cnt_q + 1'b1 == FRAME_W'(AUTO_FRAMES));
        // A real and a forced trigger in the same cycle land on the same wr_ptr.
        if (real_trig || force_trig) begin
          start_ptr_d = wr_ptr_q - pretrig_l_q;
          fill_cnt_d  = trig_fill;
          state_d     = (trig_fill == post_target) ? end_state : ST_POST;
        end
      end
      ST_POST: begin
        if (data_we) begin
          fill_cnt_d = fill_cnt_q + 1'b1;
          if (fill_cnt_q + 1'b1 == post_target) state_d = end_state;
        end
      end
      ST_HOLD: if (vfall_q && (frame_cnt_q + 1'b1 == FRAME_W'(HOLD_FRAMES))) start_capture = 1'b1;
      ST_DONE: if (arm) start_capture = 1'b1;
      default: state_d = ST_IDLE;
    endcase

    if (start_capture) begin
      state_d      = ST_PRE;
      mode_l_d     = mode;
      pretrig_l_d  = pretrig;
      trig_ch_l_d  = trig_ch;
      fill_cnt_d   = '0;
      prev_valid_d = 1'b0;
    end

    if (state_d != state_q) frame_cnt_d = '0;

    vsync_z_d = vsync;
    vfall_d   = vsync_z_q & ~vsync;
  end

  // Renderer: stage 1 is the RAM read, stage 2 turns samples into colour.
  always_comb begin
    logic signed [DATA_W-1:0] samp, shifted;
    logic signed [31:0]       v, y_s, edge_row;
    logic                     lit;
    logic [3:0]               r, g, b;
    samp     = '0;
    shifted  = '0;
    v        = '0;
    edge_row = '0;
    lit      = 1'b0;
    r        = 4'h0;
    g        = 4'h0;
    b        = 4'h0;
    y_s      = signed'({21'b0, y_p1_q});
    rd_addr  = start_ptr_q + x[DEPTH_LOG2-1:0];
    y_p1_d   = y;
    en_p1_d  = (state_q == ST_HOLD || state_q == ST_DONE) && ({1'b0, x} < 13'(DEPTH));
    for (int k = 0; k < N_CH; k++) begin
      samp    = rd_data_q[k*DATA_W +: DATA_W];
      shifted = samp >>> V_SHIFT;
      v       = {{(32-DATA_W){shifted[DATA_W-1]}}, shifted};
      if (v > 32'sd255) v = 32'sd255;
      else if (v < -32'sd256) v = -32'sd256;
      edge_row = Y_CENTER - v;
      if (v > 0)      lit = (edge_row <= y_s) && (y_s < Y_CENTER);
      else if (v < 0) lit = (Y_CENTER < y_s) && (y_s <= edge_row);
      else            lit = (y_s == Y_CENTER);
      if (lit) begin
        case (k)
          0:       g = 4'hF;
          1:       r = 4'hF;
          2:       b = 4'hF;
          default: begin r = 4'hF; g = 4'hF; b = 4'hF; end
        endcase
      end
    end
    vga_r_d = en_p1_q ? r : 4'h0;
    vga_g_d = en_p1_q ? g : 4'h0;
    vga_b_d = en_p1_q ? b : 4'h0;
  end

  // Sample RAM: not reset, written only while capturing, read every cycle.
  always_ff @(posedge clk) begin
    if (we_ram) mem[wr_ptr_q] <= data;
    rd_data_q <= mem[rd_addr];
  end

  // Control and pixel pipeline registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      start_ptr_q  <= '0;
      fill_cnt_q   <= '0;
      frame_cnt_q  <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      mode_l_q     <= '0;
      pretrig_l_q  <= '0;
      trig_ch_l_q  <= '0;
      vsync_z_q    <= 1'b0;
      vfall_q      <= 1'b0;
      y_p1_q       <= '0;
      en_p1_q      <= 1'b0;
      vga_r_q      <= '0;
      vga_g_q      <= '0;
      vga_b_q      <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      start_ptr_q  <= start_ptr_d;
      fill_cnt_q   <= fill_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      mode_l_q     <= mode_l_d;
      pretrig_l_q  <= pretrig_l_d;
      trig_ch_l_q  <= trig_ch_l_d;
      vsync_z_q    <= vsync_z_d;
      vfall_q      <= vfall_d;
      y_p1_q       <= y_p1_d;
      en_p1_q      <= en_p1_d;
      vga_r_q      <= vga_r_d;
      vga_g_q      <= vga_g_d;
      vga_b_q      <= vga_b_d;
    end
  end

  assign vga_r = vga_r_q;
  assign vga_g = vga_g_q;
  assign vga_b = vga_b_q;
  assign state = state_q;

endmodule
